// File: rtl/serv_ibus_prefetch.sv
// One-entry next-word prefetch buffer sitting between the SERV instruction bus and
// instruction memory. Sequential fetches hit the buffer; branches fall back to memory.
module serv_ibus_prefetch #(
   parameter int unsigned WITH_PREFETCH = 1
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_inv,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   output logic [31:0] o_mem_adr,
   output logic        o_mem_cyc,
   input  logic [31:0] i_mem_rdt,
   input  logic        i_mem_ack
);

   localparam int unsigned WordW = 30;

   localparam logic [1:0] EncIdle     = 2'd0;
   localparam logic [1:0] EncFetch    = 2'd1;
   localparam logic [1:0] EncPrefetch = 2'd2;
   localparam logic [1:0] EncHold     = 2'd3;

   typedef enum logic [1:0] {
      StIdle     = EncIdle,
      StFetch    = EncFetch,
      StPrefetch = EncPrefetch,
      StHold     = EncHold
   } state_e;

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   logic [WordW-1:0] tag_q, tag_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      rdt_q, rdt_d;
   logic             ack_q, ack_d;
   logic             mem_cyc_q, mem_cyc_d;
   logic [WordW-1:0] mem_adr_q, mem_adr_d;
   logic [WordW-1:0] last_q, last_d;
   logic             kill_q, kill_d;

   logic [WordW-1:0] req_word;
   logic             hit;
   logic             pf_match;
   logic             unused_adr_bits;

   assign req_word        = i_ibus_adr[31:2];
   assign unused_adr_bits = ^i_ibus_adr[1:0];

   // An invalidate in the same cycle as a lookup wins over the hit.
   assign hit      = valid_q && !i_inv && (tag_q == req_word);
   assign pf_match = !kill_q && !i_inv && (mem_adr_q == req_word);

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      tag_d     = tag_q;
      data_d    = data_q;
      rdt_d     = rdt_q;
      ack_d     = 1'b0;
      mem_cyc_d = mem_cyc_q;
      mem_adr_d = mem_adr_q;
      last_d    = last_q;
      kill_d    = kill_q;

      case (state_q)
         StIdle: begin
            if (i_ibus_cyc) begin
               if (hit) begin
                  rdt_d   = data_q;
                  ack_d   = 1'b1;
                  valid_d = 1'b0;
                  last_d  = tag_q;
                  state_d = StHold;
               end else begin
                  mem_cyc_d = 1'b1;
                  mem_adr_d = req_word;
                  valid_d   = 1'b0;
                  state_d   = StFetch;
               end
            end
         end

         StFetch: begin
            if (i_mem_ack) begin
               mem_cyc_d = 1'b0;
               rdt_d     = i_mem_rdt;
               ack_d     = 1'b1;
               last_d    = mem_adr_q;
               state_d   = StHold;
            end
         end

         StHold: begin
            if (WITH_PREFETCH != 0) begin
               mem_cyc_d = 1'b1;
               mem_adr_d = last_q + WordW'(1);
               valid_d   = 1'b0;
               kill_d    = 1'b0;
               state_d   = StPrefetch;
            end else begin
               state_d = StIdle;
            end
         end

         StPrefetch: begin
            if (i_inv) begin
               kill_d = 1'b1;
            end
            // The memory cycle is always run to completion; the data is then
            // forwarded, buffered or dropped depending on what the CPU wants.
            if (i_mem_ack) begin
               mem_cyc_d = 1'b0;
               state_d   = StIdle;
               if (i_ibus_cyc) begin
                  if (pf_match) begin
                     rdt_d   = i_mem_rdt;
                     ack_d   = 1'b1;
                     last_d  = mem_adr_q;
                     state_d = StHold;
                  end
               end else if (!kill_q && !i_inv) begin
                  data_d  = i_mem_rdt;
                  tag_d   = mem_adr_q;
                  valid_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (i_inv) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         valid_q   <= 1'b0;
         tag_q     <= '0;
         data_q    <= '0;
         rdt_q     <= '0;
         ack_q     <= 1'b0;
         mem_cyc_q <= 1'b0;
         mem_adr_q <= '0;
         last_q    <= '0;
         kill_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
         rdt_q     <= rdt_d;
         ack_q     <= ack_d;
         mem_cyc_q <= mem_cyc_d;
         mem_adr_q <= mem_adr_d;
         last_q    <= last_d;
         kill_q    <= kill_d;
      end
   end

   assign o_ibus_rdt = rdt_q;
   assign o_ibus_ack = ack_q;
   assign o_mem_cyc  = mem_cyc_q;
   assign o_mem_adr  = {mem_adr_q, 2'b00};

endmodule
